// File: rtl/crossbar_switch_param.sv
// crossbar_switch_param
//   Registered NPORTS x NPORTS wormhole crossbar for the NoC router.
//   Each output runs its own round-robin arbiter over head flits and locks
//   to the winning input until that packet's tail has passed. Every output
//   has a single register stage with a valid/ready handshake.
//
// Parameters
//   NPORTS  number of ports (index 0..4 = N,S,W,E,L for the default of 5)
//   DW      flit data width
//   DESTW   destination index width, derived from NPORTS
//
// Ports
//   clk_i        rising-edge clock
//   rst_n_i      synchronous active-low reset
//   in_data_i    input flits, port p at [p*DW +: DW]
//   in_dest_i    output index per input, read on head flits only
//   in_head_i    flit is a packet head
//   in_tail_i    flit is a packet tail (head & tail = single-flit packet)
//   in_valid_i   flit present on input
//   in_ready_o   input flit accepted this cycle when valid & ready
//   out_data_o   registered output flits
//   out_tail_o   registered tail flags
//   out_valid_o  output register holds a flit
//   out_ready_i  downstream accepts the output flit
//   err_o        pulses for one cycle when an illegal U-turn head is dropped
//
// Build option
//   CROSSBAR_UTURN_EN  when defined, a head addressed to its own port is an
//                      ordinary request (loop-back) and err_o is tied low.
//                      When undefined, such a head is swallowed at once and
//                      flagged on err_o.
module crossbar_switch_param #(
    parameter int  NPORTS = 5,
    parameter int  DW     = 16,
    localparam int DESTW  = $clog2(NPORTS)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [NPORTS*DW-1:0]    in_data_i,
    input  logic [NPORTS*DESTW-1:0] in_dest_i,
    input  logic [NPORTS-1:0]       in_head_i,
    input  logic [NPORTS-1:0]       in_tail_i,
    input  logic [NPORTS-1:0]       in_valid_i,
    output logic [NPORTS-1:0]       in_ready_o,
    output logic [NPORTS*DW-1:0]    out_data_o,
    output logic [NPORTS-1:0]       out_tail_o,
    output logic [NPORTS-1:0]       out_valid_o,
    input  logic [NPORTS-1:0]       out_ready_i,
    output logic                    err_o
);

    // Round-robin pointer wrap: the port after p, modulo NPORTS.
    function automatic logic [DESTW-1:0] next_ptr(input logic [DESTW-1:0] p);
        if (p == DESTW'(NPORTS - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Per-output and per-input control state
    logic [NPORTS-1:0] lock_q;
    logic [NPORTS-1:0] bound_q;
    logic [DESTW-1:0]  owner_q     [NPORTS];
    logic [DESTW-1:0]  rr_ptr_q    [NPORTS];
    logic [DESTW-1:0]  bound_dst_q [NPORTS];

    // Output register stage
    logic [NPORTS*DW-1:0] out_data_p1;
    logic [NPORTS-1:0]    out_tail_p1;
    logic [NPORTS-1:0]    vld_p1;

    // Arbitration stage (combinational)
    logic [NPORTS-1:0] uturn_p0;
    logic [NPORTS-1:0] req_p0  [NPORTS];  // req_p0[o][i]: input i wants output o
    logic [NPORTS-1:0] gnt_p0  [NPORTS];
    logic [DESTW-1:0]  win_p0  [NPORTS];
    logic [DW-1:0]     mux_data_p0 [NPORTS];
    logic [NPORTS-1:0] mux_head_p0;
    logic [NPORTS-1:0] mux_tail_p0;
    logic [NPORTS-1:0] space_p0;
    logic [NPORTS-1:0] xfer_p0;
    logic [NPORTS-1:0] rdy_p0;

    // ---- stage p0: U-turn detection, requests, arbitration ----
`ifdef CROSSBAR_UTURN_EN
    assign uturn_p0 = '0;
    assign err_o    = 1'b0;
`else
    always_comb begin
        uturn_p0 = '0;
        for (int i = 0; i < NPORTS; i++) begin
            uturn_p0[i] = in_valid_i[i] && in_head_i[i] && !bound_q[i] &&
                          (in_dest_i[i*DESTW +: DESTW] == DESTW'(i));
        end
    end
    assign err_o = rst_n_i && (|uturn_p0);
`endif

    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            req_p0[o] = '0;
            for (int i = 0; i < NPORTS; i++) begin
                // Out-of-range destinations never match any o, so they stall.
                req_p0[o][i] = in_valid_i[i] &&
                    ((in_head_i[i] && !bound_q[i] && !uturn_p0[i] &&
                      (in_dest_i[i*DESTW +: DESTW] == DESTW'(o))) ||
                     (!in_head_i[i] && bound_q[i] &&
                      (bound_dst_q[i] == DESTW'(o))));
            end
        end
    end

    always_comb begin
        logic found;
        int   idx;
        found = 1'b0;
        idx   = 0;
        for (int o = 0; o < NPORTS; o++) begin
            gnt_p0[o] = '0;
            if (lock_q[o]) begin
                gnt_p0[o][owner_q[o]] = req_p0[o][owner_q[o]];
            end else begin
                found = 1'b0;
                for (int k = 0; k < NPORTS; k++) begin
                    idx = (int'(rr_ptr_q[o]) + k) % NPORTS;
                    if (!found && req_p0[o][idx]) begin
                        gnt_p0[o][idx] = 1'b1;
                        found          = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        rdy_p0 = uturn_p0;
        for (int o = 0; o < NPORTS; o++) begin
            win_p0[o]      = '0;
            mux_data_p0[o] = '0;
            mux_head_p0[o] = 1'b0;
            mux_tail_p0[o] = 1'b0;
            space_p0[o]    = !vld_p1[o] || out_ready_i[o];
            for (int i = 0; i < NPORTS; i++) begin
                if (gnt_p0[o][i]) begin
                    win_p0[o]      = DESTW'(i);
                    mux_data_p0[o] = in_data_i[i*DW +: DW];
                    mux_head_p0[o] = in_head_i[i];
                    mux_tail_p0[o] = in_tail_i[i];
                end
                rdy_p0[i] = rdy_p0[i] || (gnt_p0[o][i] && space_p0[o]);
            end
            xfer_p0[o] = rst_n_i && space_p0[o] && (|gnt_p0[o]);
        end
    end

    assign in_ready_o = rdy_p0 & {NPORTS{rst_n_i}};

    // ---- stage p1: output registers and lock/bind bookkeeping ----
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            lock_q      <= '0;
            bound_q     <= '0;
            vld_p1      <= '0;
            out_tail_p1 <= '0;
            out_data_p1 <= '0;
            for (int o = 0; o < NPORTS; o++) begin
                owner_q[o]     <= '0;
                rr_ptr_q[o]    <= '0;
                bound_dst_q[o] <= '0;
            end
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                if (xfer_p0[o]) begin
                    out_data_p1[o*DW +: DW] <= mux_data_p0[o];
                    out_tail_p1[o]          <= mux_tail_p0[o];
                    vld_p1[o]               <= 1'b1;
                    if (mux_tail_p0[o]) begin
                        lock_q[o]            <= 1'b0;
                        bound_q[win_p0[o]]   <= 1'b0;
                        rr_ptr_q[o]          <= next_ptr(win_p0[o]);
                    end else if (mux_head_p0[o]) begin
                        lock_q[o]              <= 1'b1;
                        owner_q[o]             <= win_p0[o];
                        bound_q[win_p0[o]]     <= 1'b1;
                        bound_dst_q[win_p0[o]] <= DESTW'(o);
                    end
                end else if (out_ready_i[o]) begin
                    vld_p1[o] <= 1'b0;
                end
            end
        end
    end

    assign out_data_o  = out_data_p1;
    assign out_tail_o  = out_tail_p1;
    assign out_valid_o = vld_p1;

endmodule

// File: tb/tb_crossbar_switch_param.sv
// tb_crossbar_switch_param
//   Bench for crossbar_switch_param (NPORTS=5, DW=16). A table of one-cycle
//   vectors exercises arbitration from the reset state; packet sequences are
//   driven from per-input source queues while expected flits are queued per
//   output in the order the arbitration rules dictate.
module tb_crossbar_switch_param;

    localparam int NP = 5;
    localparam int DW = 16;
    localparam int DEW = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NP*DW-1:0]   in_data;
    logic [NP*DEW-1:0]  in_dest;
    logic [NP-1:0]      in_head, in_tail, in_valid, in_ready;
    logic [NP*DW-1:0]   out_data;
    logic [NP-1:0]      out_tail, out_valid, out_ready;
    logic               err;

    crossbar_switch_param #(.NPORTS(NP), .DW(DW)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_data_i   (in_data),
        .in_dest_i   (in_dest),
        .in_head_i   (in_head),
        .in_tail_i   (in_tail),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_tail_o  (out_tail),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [DEW-1:0] dest;
        logic           head;
        logic           tail;
    } flit_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          tail;
    } exp_t;

    typedef struct {
        logic [NP-1:0]          vld;
        logic [NP-1:0][DEW-1:0] dst;
        logic [NP-1:0]          ordy;
        logic [NP-1:0]          exp_rdy;
        logic                   exp_err;
        logic [NP-1:0]          exp_ovld;
    } vec_t;

    flit_t src_q [NP][$];
    exp_t  sb_q  [NP][$];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int base_c = 0;
    int first_c [NP];
    int last_c  [NP];
    int cnt_c   [NP];

    logic [NP-1:0]    ordy_v;
    logic [NP-1:0]    rdy_s, ov_s, ot_s;
    logic [NP*DW-1:0] od_s;
    logic             err_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [NP-1:0] vld, input int d0, input int d1,
                                input int d2, input int d3, input int d4,
                                input logic [NP-1:0] ordy, input logic [NP-1:0] rdy,
                                input logic e, input logic [NP-1:0] ovld);
        vec_t v;
        v.vld = vld;
        v.dst[0] = 3'(d0); v.dst[1] = 3'(d1); v.dst[2] = 3'(d2);
        v.dst[3] = 3'(d3); v.dst[4] = 3'(d4);
        v.ordy = ordy; v.exp_rdy = rdy; v.exp_err = e; v.exp_ovld = ovld;
        return v;
    endfunction

    function automatic bit pending();
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() != 0 || sb_q[p].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic flush();
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            sb_q[p].delete();
        end
    endtask

    task automatic clear_stats();
        base_c = cyc;
        for (int p = 0; p < NP; p++) begin
            first_c[p] = 0; last_c[p] = 0; cnt_c[p] = 0;
        end
    endtask

    // Queue a packet on input src for output dst; a U-turn head is dropped by
    // the switch unless loop-back is enabled, so nothing is expected then.
    task automatic send_pkt(input int src, input int dst, input int len, input logic [DW-1:0] base);
        flit_t f;
        exp_t  e;
        for (int k = 0; k < len; k++) begin
            f.data = base + DW'(k);
            f.dest = 3'(dst);
            f.head = (k == 0);
            f.tail = (k == len - 1);
            src_q[src].push_back(f);
`ifndef CROSSBAR_UTURN_EN
            if (src == dst) continue;
`endif
            e.data = f.data;
            e.tail = f.tail;
            sb_q[dst].push_back(e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cycle();
        flit_t f;
        exp_t  e;
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() != 0) begin
                f = src_q[p][0];
                in_valid[p] = 1'b1;
                in_head[p]  = f.head;
                in_tail[p]  = f.tail;
                in_data[p*DW +: DW]   = f.data;
                in_dest[p*DEW +: DEW] = f.dest;
            end else begin
                in_valid[p] = 1'b0;
                in_head[p]  = 1'b0;
                in_tail[p]  = 1'b0;
                in_data[p*DW +: DW]   = '0;
                in_dest[p*DEW +: DEW] = '0;
            end
        end
        out_ready = ordy_v;
        #1;
        rdy_s = in_ready; ov_s = out_valid; od_s = out_data; ot_s = out_tail; err_s = err;
        @(posedge clk);
        cyc++;
        for (int p = 0; p < NP; p++) begin
            if (in_valid[p] && rdy_s[p]) void'(src_q[p].pop_front());
        end
        for (int o = 0; o < NP; o++) begin
            if (ov_s[o] && ordy_v[o]) begin
                n_cmp++;
                if (sb_q[o].size() == 0) begin
                    n_fail++;
                    $display("FAIL out%0d_unexpected: got data 0x%0h tail %0b, expected no flit",
                             o, od_s[o*DW +: DW], ot_s[o]);
                end else begin
                    e = sb_q[o].pop_front();
                    if ({od_s[o*DW +: DW], ot_s[o]} !== {e.data, e.tail}) begin
                        n_fail++;
                        $display("FAIL out%0d_flit: got data 0x%0h tail %0b, expected data 0x%0h tail %0b",
                                 o, od_s[o*DW +: DW], ot_s[o], e.data, e.tail);
                    end
                    if (cnt_c[o] == 0) first_c[o] = cyc - base_c;
                    last_c[o] = cyc - base_c;
                    cnt_c[o]++;
                end
            end
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (pending() && n < budget) begin
            cycle();
            n++;
        end
        n_cmp++;
        if (pending()) begin
            n_fail++;
            $display("FAIL drain_%s: flits still outstanding after %0d cycles, expected none", tag, n);
            flush();
        end
        repeat (2) cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [8];
        logic [NP-1:0] ur_exp;

        // Reset state: inputs all active, including a U-turn head on E.
        rst_n = 1'b0;
        in_valid = '1; in_head = '1; in_tail = '1;
        in_data = {NP{16'hFFFF}};
        in_dest = {3'd0, 3'd3, 3'd4, 3'd1, 3'd2};
        out_ready = '1; ordy_v = '1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_err", err, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_tail", out_tail, 0);
        check("rst_out_data_lo", out_data[31:0], 0);
        check("rst_out_data_hi", out_data[79:32], 0);

        // Single-flit vectors, each applied straight out of reset (rr pointers 0).
        tbl[0] = mk(5'b00100, 0, 0, 3, 0, 0, 5'b11111, 5'b00100, 1'b0, 5'b01000);
        tbl[1] = mk(5'b00011, 4, 4, 0, 0, 0, 5'b11111, 5'b00001, 1'b0, 5'b10000);
        tbl[2] = mk(5'b00001, 5, 0, 0, 0, 0, 5'b11111, 5'b00000, 1'b0, 5'b00000);
        tbl[3] = mk(5'b01111, 1, 2, 3, 0, 0, 5'b11111, 5'b01111, 1'b0, 5'b01111);
        tbl[5] = mk(5'b00100, 0, 0, 3, 0, 0, 5'b00000, 5'b00100, 1'b0, 5'b01000);
        tbl[7] = mk(5'b00000, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, 1'b0, 5'b00000);
`ifdef CROSSBAR_UTURN_EN
        tbl[4] = mk(5'b01000, 0, 0, 0, 3, 0, 5'b11111, 5'b01000, 1'b0, 5'b01000);
        tbl[6] = mk(5'b11111, 0, 0, 0, 0, 0, 5'b11111, 5'b00001, 1'b0, 5'b00001);
`else
        tbl[4] = mk(5'b01000, 0, 0, 0, 3, 0, 5'b11111, 5'b01000, 1'b1, 5'b00000);
        tbl[6] = mk(5'b11111, 0, 0, 0, 0, 0, 5'b11111, 5'b00011, 1'b1, 5'b00001);
`endif
        for (int v = 0; v < 8; v++) begin
            do_reset();
            in_valid = tbl[v].vld;
            in_head  = tbl[v].vld;
            in_tail  = tbl[v].vld;
            in_dest  = tbl[v].dst;
            for (int p = 0; p < NP; p++) in_data[p*DW +: DW] = 16'(16'h1000 * (p + 1) + v);
            out_ready = tbl[v].ordy;
            #1;
            check($sformatf("vec%0d_in_ready", v), in_ready, tbl[v].exp_rdy);
            check($sformatf("vec%0d_err", v), err, tbl[v].exp_err);
            @(posedge clk);
            @(negedge clk);
            in_valid = '0;
            #1;
            check($sformatf("vec%0d_out_valid", v), out_valid, tbl[v].exp_ovld);
            check($sformatf("vec%0d_out_tail", v), out_tail, tbl[v].exp_ovld);
        end
        ur_exp = '1;
        out_ready = ur_exp;
        do_reset();

        // W -> E single flit, output one cycle after acceptance.
        clear_stats();
        send_pkt(2, 3, 1, 16'hA5A5);
        drain("w_to_e", 20);
        check("w_to_e_latency", first_c[3], 2);

        // N and S contend for L; N first, then S, then the pointer favours W over N.
        send_pkt(0, 4, 3, 16'h4000);
        send_pkt(1, 4, 3, 16'h4100);
        drain("ns_to_l", 40);
        send_pkt(2, 4, 1, 16'h4300);
        send_pkt(0, 4, 1, 16'h4200);
        drain("rr_after_s", 20);

        // Backpressure on E in the middle of a W -> E packet.
        send_pkt(2, 3, 4, 16'h3000);
        cycle();
        cycle();
        ordy_v[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check($sformatf("stall%0d_w_ready", k), rdy_s[2], 0);
            check($sformatf("stall%0d_e_data", k), od_s[3*DW +: DW], 16'h3001);
        end
        ordy_v[3] = 1'b1;
        drain("stall_release", 40);

        // Four concurrent 8-flit packets to distinct outputs.
        clear_stats();
        send_pkt(0, 1, 8, 16'h7000);
        send_pkt(1, 2, 8, 16'h7100);
        send_pkt(2, 3, 8, 16'h7200);
        send_pkt(3, 0, 8, 16'h7300);
        drain("four_way", 60);
        for (int o = 0; o < 4; o++) begin
            check($sformatf("four_way_cnt%0d", o), cnt_c[o], 8);
            check($sformatf("four_way_span%0d", o), last_c[o] - first_c[o], 7);
        end

        // Reset after two flits of a four-flit packet.
        send_pkt(2, 3, 4, 16'h5000);
        cycle();
        cycle();
        do_reset();
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data_e", out_data[3*DW +: DW], 0);
        flush();
        send_pkt(1, 3, 1, 16'h5100);
        send_pkt(2, 0, 1, 16'h5200);
        drain("after_reset", 20);

        // Head on E addressed to E.
        send_pkt(3, 3, 1, 16'h6000);
        cycle();
        check("uturn_ready", rdy_s[3], 1);
`ifdef CROSSBAR_UTURN_EN
        check("uturn_err", err_s, 0);
`else
        check("uturn_err", err_s, 1);
`endif
        drain("uturn", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
